// File: rtl/maple_bus_sequencer.sv
// maple_bus_sequencer: runs one Maple Bus command/response exchange. It gates the TX enable,
// holds a turnaround gap, opens the receiver, and applies a timeout to both wait phases.
// Optional feature: define MAPLE_SEQ_AUTOSTART_EN to start a transaction automatically
// whenever a TX packet is queued. The start input is then ignored.
module maple_bus_sequencer #(
   parameter int unsigned C_DATA_COUNT_WIDTH  = 11,
   parameter int unsigned C_TIMER_WIDTH       = 24,
   parameter int unsigned C_TURNAROUND_CYCLES = 16,
   parameter int unsigned C_TIMEOUT_CYCLES    = 100000
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic                          start,
   input  logic                          abort,
   input  logic [C_DATA_COUNT_WIDTH-1:0] tx_packet_count,
   input  logic [C_DATA_COUNT_WIDTH-1:0] rx_packet_count,
   input  logic                          transmitting,
   input  logic                          receiving,
   output logic                          enable_tx,
   output logic                          enable_rx,
   output logic                          busy,
   output logic                          done,
   output logic [1:0]                    status
);

   localparam logic [C_TIMER_WIDTH-1:0] TimeoutLast = C_TIMER_WIDTH'(C_TIMEOUT_CYCLES - 1);
   localparam logic [C_TIMER_WIDTH-1:0] TurnLast    = C_TIMER_WIDTH'(C_TURNAROUND_CYCLES - 1);
   localparam logic [C_TIMER_WIDTH-1:0] TimerMax    = '1;

   localparam logic [1:0] StatusNone    = 2'b00;
   localparam logic [1:0] StatusOk      = 2'b01;
   localparam logic [1:0] StatusTxTmo   = 2'b10;
   localparam logic [1:0] StatusRxTmo   = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StTxWait,
      StTxActive,
      StTurnaround,
      StRxWait,
      StRxActive
   } state_e;

   state_e                        state_q, state_d;
   logic [C_TIMER_WIDTH-1:0]      timer_q, timer_d, timer_inc;
   logic [C_DATA_COUNT_WIDTH-1:0] rx_base_q, rx_base_d;
   logic [1:0]                    status_d;
   logic                          done_d;
   logic                          start_req;
   logic                          rx_pair_move;

`ifdef MAPLE_SEQ_AUTOSTART_EN
   logic unused_start;
   assign unused_start = start;
   // IDLE is always entered for at least one cycle after done, which gives the required gap.
   assign start_req = 1'b1;
`else
   assign start_req = start;
`endif

   // Saturating increment of the shared phase timer.
   always_comb begin
      timer_inc = (timer_q == TimerMax) ? timer_q : timer_q + 1'b1;
   end

   // Next-state, timer, captured RX count and result decode.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_inc;
      rx_base_d = rx_base_q;
      status_d  = status;
      done_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!abort && start_req && (tx_packet_count != '0)) begin
               state_d  = StTxWait;
               status_d = StatusNone;
            end
         end
         StTxWait: begin
            if (transmitting) begin
               state_d = StTxActive;
            end else if (timer_q == TimeoutLast) begin
               state_d  = StIdle;
               status_d = StatusTxTmo;
               done_d   = 1'b1;
            end
         end
         StTxActive: begin
            if (!transmitting) state_d = StTurnaround;
         end
         StTurnaround: begin
            if (timer_q == TurnLast) begin
               state_d   = StRxWait;
               rx_base_d = rx_packet_count;
            end
         end
         StRxWait: begin
            if (receiving) begin
               state_d = StRxActive;
            end else if (timer_q >= TimeoutLast) begin
               // >= because time spent in a rejected RX_ACTIVE can carry the timer past the limit.
               state_d  = StIdle;
               status_d = StatusRxTmo;
               done_d   = 1'b1;
            end
         end
         StRxActive: begin
            if (!receiving) begin
               if (rx_packet_count != rx_base_q) begin
                  state_d  = StIdle;
                  status_d = StatusOk;
                  done_d   = 1'b1;
               end else begin
                  state_d = StRxWait;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // The RX wait/active pair shares one timeout window, so moves within it keep the timer.
      rx_pair_move = ((state_q == StRxWait) && (state_d == StRxActive)) ||
                     ((state_q == StRxActive) && (state_d == StRxWait));
      if ((state_d != state_q) && !rx_pair_move) timer_d = '0;
      if (state_q == StIdle) timer_d = '0;

      if (abort && (state_q != StIdle)) begin
         state_d  = StIdle;
         status_d = StatusNone;
         done_d   = 1'b1;
         timer_d  = '0;
      end
   end

   // State register; all outputs are registered from the next state.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= StIdle;
         timer_q   <= '0;
         rx_base_q <= '0;
         enable_tx <= 1'b0;
         enable_rx <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         status    <= StatusNone;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         rx_base_q <= rx_base_d;
         enable_tx <= (state_d == StTxWait) || (state_d == StTxActive);
         enable_rx <= (state_d == StRxWait) || (state_d == StRxActive);
         busy      <= (state_d != StIdle);
         done      <= done_d;
         status    <= status_d;
      end
   end

endmodule
